// File: rtl/cv32e40px_x_wb_buffer.sv
// Queues eXtension-interface results and drains them to register-file port B when core writeback is idle.
// Latency: one cycle push-to-write (no bypass); ready drops only when all DEPTH entries are occupied.
module cv32e40px_x_wb_buffer #(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned X_DUALWRITE = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  x_result_valid_i,
    output logic                                  x_result_ready_o,
    input  logic [ADDR_WIDTH-1:0]                 x_result_rd_i,
    input  logic                                  x_result_we_i,
    input  logic                                  x_result_dualwrite_i,
    input  logic [(X_DUALWRITE+1)*DATA_WIDTH-1:0] x_result_data_i,
    input  logic                                  wb_busy_i,
    input  logic [ADDR_WIDTH-1:0]                 raddr_a_i,
    input  logic [ADDR_WIDTH-1:0]                 raddr_b_i,
    input  logic [ADDR_WIDTH-1:0]                 raddr_c_i,
    output logic [2:0]                            hazard_o,
    output logic [ADDR_WIDTH-1:0]                 waddr_o,
    output logic [(X_DUALWRITE+1)*DATA_WIDTH-1:0] wdata_o,
    output logic                                  we_o,
    output logic                                  dualwrite_o,
    output logic                                  empty_o
);

    localparam int unsigned XW = (X_DUALWRITE + 1) * DATA_WIDTH;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic                  dual;
        logic [XW-1:0]         data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [CW-1:0]     count_q;

    logic              push;
    logic              store;
    logic              pop;
    logic              dual_in;
    entry_t            new_entry;
    entry_t            head;
    logic [ADDR_WIDTH-1:0] raddr [3];

    assign x_result_ready_o = (count_q != CW'(DEPTH));
    assign push             = x_result_valid_i & x_result_ready_o;
    assign dual_in          = (X_DUALWRITE != 0) && x_result_dualwrite_i;

    always_comb begin
        new_entry      = '0;
        new_entry.rd   = x_result_rd_i;
        new_entry.dual = dual_in;
        new_entry.data = x_result_data_i;
        // Pair writes always target the even register of the aligned pair.
        if (dual_in) begin
            new_entry.rd[0] = 1'b0;
        end
    end

    // Writes to integer x0 are dropped unless they are part of a pair.
    assign store = push && x_result_we_i && !((x_result_rd_i == '0) && !dual_in);

    assign empty_o = (count_q == '0);
    assign pop     = !empty_o && !wb_busy_i;
    assign head    = mem_q[rptr_q];

    assign we_o        = pop;
    assign dualwrite_o = pop & head.dual;
    assign waddr_o     = head.rd;
    assign wdata_o     = head.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            vld_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (store) begin
                mem_q[wptr_q] <= new_entry;
                vld_q[wptr_q] <= 1'b1;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (pop) begin
                vld_q[rptr_q] <= 1'b0;
                rptr_q        <= rptr_q + PW'(1);
            end
            count_q <= count_q + CW'(store) - CW'(pop);
        end
    end

    function automatic logic addr_match(input logic [ADDR_WIDTH-1:0] ra,
                                        input logic [ADDR_WIDTH-1:0] rd,
                                        input logic                  dual);
        logic [ADDR_WIDTH-1:0] ra_even;
        ra_even    = ra;
        ra_even[0] = 1'b0;
        if (ra == '0) begin
            return 1'b0;
        end
        return dual ? (ra_even == rd) : (ra == rd);
    endfunction

    assign raddr[0] = raddr_a_i;
    assign raddr[1] = raddr_b_i;
    assign raddr[2] = raddr_c_i;

    // The entry being drained keeps flagging until it actually leaves the FIFO.
    always_comb begin
        hazard_o = '0;
        for (int k = 0; k < 3; k++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (vld_q[e] && addr_match(raddr[k], mem_q[e].rd, mem_q[e].dual)) begin
                    hazard_o[k] = 1'b1;
                end
            end
            if (store && addr_match(raddr[k], new_entry.rd, new_entry.dual)) begin
                hazard_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: doc/cv32e40px_x_wb_buffer.md
Name: cv32e40px_x_wb_buffer

Overview:
- Writeback buffer between the eXtension-interface (coprocessor) result channel and register-file write port B.
- Accepts X results with a valid/ready handshake and queues them in a small FIFO.
- Drains each entry to the register file when the core's own writeback is not using port B, including register-pair (dual) writes.
- Reports read-after-write hazards for pending entries so the decode stage can stall operand reads.

Parameters:
- ADDR_WIDTH, 6, register address width; bit 5 selects the FP bank, bits 4:0 the index.
- DATA_WIDTH, 32, register data width.
- DEPTH, 2, FIFO entries; power of two, at least 2.
- X_DUALWRITE, 0, 1 enables register-pair writes (second data lane).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- x_result_valid_i  in  1  result offered.
- x_result_ready_o  out  1  buffer can accept.
- x_result_rd_i  in  ADDR_WIDTH  destination register.
- x_result_we_i  in  1  result writes a register.
- x_result_dualwrite_i  in  1  write the pair rd, rd|1.
- x_result_data_i  in  (X_DUALWRITE+1)*DATA_WIDTH  lane 0 goes to rd, lane 1 to rd|1.
- wb_busy_i  in  1  core writeback owns port B this cycle.
- raddr_a_i, raddr_b_i, raddr_c_i  in  ADDR_WIDTH each  decode-stage read addresses.
- hazard_o  out  3  bit k is set when read address k (a, b, c) targets a pending write.
- waddr_o  out  ADDR_WIDTH  write address to port B, always even when dualwrite_o=1.
- wdata_o  out  (X_DUALWRITE+1)*DATA_WIDTH  write data.
- we_o  out  1  write enable to port B.
- dualwrite_o  out  1  pair write.
- empty_o  out  1  no pending entries.

Behaviour:
- Reset (asynchronous, active-low):
  - Pointers and count clear; all entry-valid bits clear.
  - x_result_ready_o=1, we_o=0, dualwrite_o=0, waddr_o=0, wdata_o=0, hazard_o=0, empty_o=1.
- Storage: circular FIFO with DEPTH entries. Each entry holds rd, dualwrite, and the data lanes. The read and write pointers wrap modulo DEPTH. A count of log2(DEPTH)+1 bits tracks occupancy.
- Handshake:
  - x_result_ready_o = (count != DEPTH). It is a function of registered state only and does not depend on x_result_valid_i.
  - A push happens on a rising clk edge when valid and ready are both 1.
  - Once valid is raised, the producer holds it and the data stable until ready.
- Filtering at push:
  - we_i=0: handshake completes, nothing is stored.
  - Integer x0 (rd=6'b000000) with dualwrite=0: handshake completes, nothing is stored.
  - X_DUALWRITE=1, dualwrite=1: rd[0] is cleared before storing. Odd rd therefore writes the aligned pair.
  - X_DUALWRITE=0: x_result_dualwrite_i is ignored, and stored dualwrite is always 0.
- Drain (combinational from the head entry):
  - When count!=0 and wb_busy_i=0: we_o=1, waddr_o=head.rd, wdata_o=head.data, dualwrite_o=head.dualwrite.
  - The head pops on the same edge.
  - When wb_busy_i=1 or the FIFO is empty: we_o=0, dualwrite_o=0, and waddr_o/wdata_o hold the head values (don't-care).
- Latency: a result pushed at edge N appears on port B in the cycle after N (earliest) and is written at edge N+1. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Allowed whenever ready=1; count is unchanged.
  - When full, ready=0, so no push can coincide with a pop. A pop at edge N makes ready=1 in the cycle after N.
- Hazard detection:
  - hazard_o[k]=1 if raddr_k matches the rd of any valid entry.
  - For a dualwrite entry, the match is on (raddr_k & ~6'b1)==rd.
  - The result being pushed in the current cycle (valid & ready & stored) is also matched, using the same rule.
  - Integer x0 reads never flag.
  - The entry currently being drained still flags, which is conservative.
- empty_o = (count==0).
- Ordering is strict FIFO. Two entries to the same rd are written in push order.
- Asserting rst_n mid-drain discards all entries; no write is issued after reset asserts.

Test Plan:
- Reset, then push rd=6'd5, data=32'hDEADBEEF, with wb_busy_i=0 -> in the next cycle we_o=1, waddr_o=5, wdata_o=32'hDEADBEEF; empty_o=1 one cycle later.
- Hold wb_busy_i=1 and push 2 results (DEPTH=2) -> x_result_ready_o=0 and a third valid stalls. Release busy -> writes issue in order over 2 cycles, and ready=1 after the first pop.
- Push rd=0 (integer) with we=1, and rd=7 with we=0 -> handshake completes, no we_o pulse, empty_o stays 1.
- X_DUALWRITE=1: push rd=6'd9, dualwrite=1, lanes {32'h2222_2222, 32'h1111_1111} -> waddr_o=8, dualwrite_o=1, wdata_o lane0=32'h1111_1111. Meanwhile hazard_o[0]=1 for raddr_a_i=8 and for raddr_a_i=9, and 0 for raddr_a_i=10.
- FP destination rd=6'd35 pending under busy -> hazard_o[1]=1 for raddr_b_i=35 and 0 for raddr_b_i=3.
- Assert rst_n low with 2 entries pending -> count=0, we_o=0, ready=1 immediately. After release, no stale write appears.
